maxpool_2x2: RTL

Streaming 2x2, stride-2 max-pooling stage between the convolution engine and the ReLU stage. Accepts one signed convolution result per cycle in raster order, keeps a half-width line buffer of horizontal pair maxima, and emits one pooled value per completed 2x2 window. It is the direct producer of the ReLU stage's `maxpool_out` / `valid_in` inputs and honours that stage's `relu_ready` as backpressure.

---
 rtl/maxpool_2x2_if.sv | 31 +++
 rtl/maxpool_2x2.sv | 133 +++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_if.sv
// Streaming handshake bundle between the convolution engine, the 2x2 max-pool stage
// and the downstream ReLU stage.
interface maxpool_2x2_if #(
    parameter int unsigned DATA_W = 23
);
    logic signed [DATA_W-1:0] conv_out;
    logic                     valid_in;
    logic                     maxpool_ready;
    logic signed [DATA_W-1:0] maxpool_out;
    logic                     valid_out;
    logic                     relu_ready;

    // slave: the pooling stage itself; master: whoever drives it and consumes its output
    modport slave (
        input  conv_out,
        input  valid_in,
        input  relu_ready,
        output maxpool_ready,
        output maxpool_out,
        output valid_out
    );

    modport master (
        output conv_out,
        output valid_in,
        output relu_ready,
        input  maxpool_ready,
        input  maxpool_out,
        input  valid_out
    );
endinterface

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool with a half-width line buffer of pair maxima.
// Optional MAXPOOL_FRAME_DONE_EN adds a frame_done pulse on the last window of a frame.
module maxpool_2x2 #(
    parameter int unsigned DATA_W = 23,
    parameter int unsigned IN_W   = 26,
    parameter int unsigned IN_H   = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    maxpool_2x2_if.slave  bus
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    output logic          frame_done
`endif
);
    localparam int unsigned HalfW = IN_W / 2;
    localparam int unsigned ColW  = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int unsigned RowW  = (IN_H > 2) ? $clog2(IN_H) : 1;
    localparam int unsigned LbW   = (HalfW > 1) ? $clog2(HalfW) : 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [ColW-1:0]          col_q, col_d;
    logic [RowW-1:0]          row_q, row_d;
    logic signed [DATA_W-1:0] h_q, h_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     vout_q, vout_d;
    logic signed [DATA_W-1:0] lbuf_q [HalfW];

    logic                     ready;
    logic                     accept;
    logic                     lbuf_we;
    logic [LbW-1:0]           lidx;
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] hmax;
    logic signed [DATA_W-1:0] lbuf_rd;
    logic signed [DATA_W-1:0] pooled;
    logic                     last_col;
    logic                     last_row;

`ifdef MAXPOOL_FRAME_DONE_EN
    logic fd_q, fd_d;
`endif

    always_comb begin
        ready    = (state_q == StRun) && bus.relu_ready;
        accept   = bus.valid_in && ready;
        sample   = bus.conv_out;
        lidx     = LbW'(col_q >> 1);
        last_col = (col_q == ColW'(IN_W - 1));
        last_row = (row_q == RowW'(IN_H - 1));
        hmax     = (sample > h_q) ? sample : h_q;
        lbuf_rd  = lbuf_q[lidx];
        pooled   = (lbuf_rd > hmax) ? lbuf_rd : hmax;

        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        h_d      = h_q;
        out_d    = out_q;
        vout_d   = 1'b0;
        lbuf_we  = 1'b0;
`ifdef MAXPOOL_FRAME_DONE_EN
        fd_d     = 1'b0;
`endif

        if (state_q == StIdle && bus.relu_ready) begin
            state_d = StRun;
        end

        if (accept) begin
            if (!col_q[0]) begin
                h_d = sample;
            end else if (!row_q[0]) begin
                lbuf_we = 1'b1;
            end else begin
                out_d  = pooled;
                vout_d = 1'b1;
`ifdef MAXPOOL_FRAME_DONE_EN
                fd_d   = last_row && last_col;
`endif
            end

            // Raster walk; the frame wraps straight into the next one with no gap
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            out_q   <= '0;
            vout_q  <= 1'b0;
`ifdef MAXPOOL_FRAME_DONE_EN
            fd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            h_q     <= h_d;
            out_q   <= out_d;
            vout_q  <= vout_d;
`ifdef MAXPOOL_FRAME_DONE_EN
            fd_q    <= fd_d;
`endif
        end
    end

    // Line buffer is always written on an even row before the odd row reads it
    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf_q[lidx] <= hmax;
        end
    end

    assign bus.maxpool_ready = ready;
    assign bus.maxpool_out   = out_q;
    assign bus.valid_out     = vout_q;
`ifdef MAXPOOL_FRAME_DONE_EN
    assign frame_done        = fd_q;
`endif
endmodule
